// File: rtl/data_mem_lsu_if.sv
// Bundle of the LSU request/response handshake and the data-memory req/gnt/rvalid bus.
// Latency: none (wires only).
// Backpressure: lsu_ready_o stalls the writeback stage; data_gnt_i stalls the bus request.
interface data_mem_lsu_if #(
    parameter int WORD_WIDTH = 32
);
    // Writeback-stage side
    logic                  lsu_valid_i;
    logic [1:0]            lsu_ctrl_i;
    logic                  lsu_we_i;
    logic                  lsu_sext_i;
    logic [WORD_WIDTH-1:0] lsu_addr_i;
    logic [WORD_WIDTH-1:0] lsu_wdata_i;
    logic                  lsu_ready_o;
    logic [WORD_WIDTH-1:0] lsu_rdata_o;
    logic                  lsu_rvalid_o;
    logic                  lsu_err_o;

    // Data-memory bus side
    logic                  data_req_o;
    logic [WORD_WIDTH-1:0] data_addr_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [WORD_WIDTH-1:0] data_wdata_o;
    logic [WORD_WIDTH-1:0] data_rdata_i;
    logic                  data_rvalid_i;
    logic                  data_gnt_i;

    // The LSU itself: consumes pipeline requests, drives the memory bus
    modport master (
        input  lsu_valid_i, lsu_ctrl_i, lsu_we_i, lsu_sext_i, lsu_addr_i, lsu_wdata_i,
        output lsu_ready_o, lsu_rdata_o, lsu_rvalid_o, lsu_err_o,
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_rdata_i, data_rvalid_i, data_gnt_i
    );

    // Environment view: pipeline plus memory
    modport slave (
        output lsu_valid_i, lsu_ctrl_i, lsu_we_i, lsu_sext_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_ready_o, lsu_rdata_o, lsu_rvalid_o, lsu_err_o,
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_rdata_i, data_rvalid_i, data_gnt_i
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Single-outstanding load/store unit: byte-lane formatting, req/gnt/rvalid bus, load align/extend.
// Latency: best case 3 cycles from accept to lsu_rvalid_o (req+gnt, rvalid, result pulse).
// Backpressure: lsu_ready_o low outside IDLE; request held until data_gnt_i. Option: MISALIGN_TRAP_EN.
module data_mem_lsu #(
    parameter int WORD_WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_lsu_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t                r_state;
    logic [1:0]            r_size;
    logic [1:0]            r_off;
    logic                  r_sext;
    logic                  r_we;
    logic                  r_req;
    logic [WORD_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] r_rdata;
    logic                  r_rvalid;

    logic                  w_accept;
    logic                  w_misalign;
    logic [1:0]            w_off;
    logic [3:0]            w_be;
    logic [WORD_WIDTH-1:0] w_wdata;
    logic [WORD_WIDTH-1:0] w_shift;
    logic [WORD_WIDTH-1:0] w_load;

    assign w_accept = bus.lsu_valid_i && (r_state == S_IDLE) && (bus.lsu_ctrl_i != 2'b00);

`ifdef MISALIGN_TRAP_EN
    logic r_err;
    assign w_misalign = ((bus.lsu_ctrl_i == SZ_HALF) && bus.lsu_addr_i[0]) ||
                        ((bus.lsu_ctrl_i == SZ_WORD) && (bus.lsu_addr_i[1:0] != 2'b00));
    assign bus.lsu_err_o = r_err;
`else
    assign w_misalign    = 1'b0;
    assign bus.lsu_err_o = 1'b0;
`endif

    // Lane offset, byte enables and lane-replicated store data; half/word drop low address bits
    always_comb begin
        w_off   = 2'b00;
        w_be    = 4'b0000;
        w_wdata = bus.lsu_wdata_i;
        case (bus.lsu_ctrl_i)
            SZ_BYTE: begin
                w_off   = bus.lsu_addr_i[1:0];
                w_be    = 4'b0001 << bus.lsu_addr_i[1:0];
                w_wdata = {4{bus.lsu_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_off   = {bus.lsu_addr_i[1], 1'b0};
                w_be    = 4'b0011 << {bus.lsu_addr_i[1], 1'b0};
                w_wdata = {2{bus.lsu_wdata_i[15:0]}};
            end
            SZ_WORD: begin
                w_off   = 2'b00;
                w_be    = 4'b1111;
                w_wdata = bus.lsu_wdata_i;
            end
            default: begin
                w_off   = 2'b00;
                w_be    = 4'b0000;
                w_wdata = bus.lsu_wdata_i;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 and extend byte/half results
    always_comb begin
        w_shift = bus.data_rdata_i >> {r_off, 3'b000};
        case (r_size)
            SZ_BYTE: w_load = {{(WORD_WIDTH-8){r_sext & w_shift[7]}}, w_shift[7:0]};
            SZ_HALF: w_load = {{(WORD_WIDTH-16){r_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // Control FSM; every output is a register so the bus sees glitch-free, stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_size   <= 2'b00;
            r_off    <= 2'b00;
            r_sext   <= 1'b0;
            r_we     <= 1'b0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'b0000;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_rvalid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_err    <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_misalign) begin
                            // Rejected before reaching the bus; the unit stays idle
`ifdef MISALIGN_TRAP_EN
                            r_err <= 1'b1;
`endif
                        end else begin
                            r_size  <= bus.lsu_ctrl_i;
                            r_off   <= w_off;
                            r_sext  <= bus.lsu_sext_i;
                            r_we    <= bus.lsu_we_i;
                            r_addr  <= {bus.lsu_addr_i[WORD_WIDTH-1:2], 2'b00};
                            r_be    <= w_be;
                            r_wdata <= w_wdata;
                            r_req   <= 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // rvalid here cannot belong to this request and is dropped
                    if (bus.data_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.data_rvalid_i) begin
                        if (!r_we) begin
                            r_rdata <= w_load;
                        end
                        r_rvalid <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lsu_ready_o  = (r_state == S_IDLE);
    assign bus.lsu_rdata_o  = r_rdata;
    assign bus.lsu_rvalid_o = r_rvalid;
    assign bus.data_req_o   = r_req;
    assign bus.data_addr_o  = r_addr;
    assign bus.data_we_o    = r_we;
    assign bus.data_be_o    = r_be;
    assign bus.data_wdata_o = r_wdata;

endmodule
